// File: rtl/phaser_arb_pkg.sv
// Shared state encodings and helpers for the phaser run/stopped arbiter.
// Build option PHASER_ARB_RR_EN switches the picker to round-robin.
package phaser_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int IDXW     = 3;

    localparam logic [2:0] RUN       = 3'd0;
    localparam logic [2:0] STOP      = 3'd1;
    localparam logic [2:0] HELD      = 3'd2;
    localparam logic [2:0] STEP_GO   = 3'd3;
    localparam logic [2:0] STEP_WAIT = 3'd4;

    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/phaser_arb_pick.sv
// Combinational requester picker: fixed priority (index 0 wins) by default,
// round-robin starting after the last grantee when PHASER_ARB_RR_EN is defined.
module phaser_arb_pick
    import phaser_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
`ifdef PHASER_ARB_RR_EN
    input  logic [IDXW-1:0] last,
`endif
    output logic [NREQ-1:0] pick
);

`ifdef PHASER_ARB_RR_EN
    int   idx;
    logic found;

    // Walk the requesters starting one past the previous grantee, wrapping at NREQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(last) + 1 + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end
`else
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/phaser_run_arb.sv
// Stops the 65C02 via the phaser run input, grants one stop requester, sequences
// single steps and counts CPU cycles. PHASER_ARB_RR_EN selects round-robin picking.
module phaser_run_arb
    import phaser_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CNTW = 32
) (
    input  logic            clk6x,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            step,
    input  logic            stopped,
    input  logic            release_cs,
    output logic            run,
    output logic [NREQ-1:0] grant,
    output logic            step_done,
    output logic            busy,
    output logic [CNTW-1:0] cyc_cnt
);

    logic [2:0]      state, state_n;
    logic            run_n, step_done_n;
    logic            seen, seen_n;
    logic [NREQ-1:0] grant_n, pick;
    logic            grantee_req;

    assign grantee_req = |(req & grant);

`ifdef PHASER_ARB_RR_EN
    logic [IDXW-1:0] last;

    always_ff @(posedge clk6x) begin
        if (reset)
            last <= IDXW'(NREQ - 1);
        else if ((grant == '0) && (grant_n != '0))
            last <= onehot_to_idx(NREQ_MAX'(grant_n));
    end

    phaser_arb_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .last (last),
        .pick (pick)
    );
`else
    phaser_arb_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .pick (pick)
    );
`endif

    always_comb begin
        state_n     = state;
        run_n       = 1'b0;
        grant_n     = grant;
        step_done_n = 1'b0;
        seen_n      = seen;
        case (state)
            RUN: begin
                grant_n = '0;
                if (|req) state_n = STOP;
                else      run_n   = 1'b1;
            end
            STOP: begin
                if (stopped) begin
                    if (|req) begin
                        grant_n = pick;
                        state_n = HELD;
                    end else begin
                        state_n = RUN;
                        run_n   = 1'b1;
                    end
                end
            end
            HELD: begin
                if (step && grantee_req) begin
                    state_n = STEP_GO;
                    run_n   = 1'b1;
                    seen_n  = 1'b0;
                end else if (!grantee_req) begin
                    // A released grant leaves one idle cycle before the next grantee.
                    if (!(|req)) begin
                        grant_n = '0;
                        state_n = RUN;
                        run_n   = 1'b1;
                    end else if (grant != '0) begin
                        grant_n = '0;
                    end else begin
                        grant_n = pick;
                    end
                end
            end
            STEP_GO: begin
                state_n = STEP_WAIT;
            end
            STEP_WAIT: begin
                // stopped is stale until the stepped cycle has actually released.
                if (release_cs) seen_n = 1'b1;
                if (seen && stopped) begin
                    step_done_n = 1'b1;
                    state_n     = HELD;
                end
            end
            default: begin
                state_n = STOP;
            end
        endcase
    end

    always_ff @(posedge clk6x) begin
        if (reset) begin
            state     <= STOP;
            run       <= 1'b0;
            grant     <= '0;
            step_done <= 1'b0;
            busy      <= 1'b1;
            seen      <= 1'b0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            grant     <= grant_n;
            step_done <= step_done_n;
            busy      <= (state_n != RUN);
            seen      <= seen_n;
        end
    end

    always_ff @(posedge clk6x) begin
        if (reset)
            cyc_cnt <= '0;
        else if (release_cs)
            cyc_cnt <= cyc_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_phaser_run_arb.sv
// Directed bench for phaser_run_arb with a simple six-microcycle phaser model.
// Expectations for the alternation test depend on PHASER_ARB_RR_EN.
module tb_phaser_run_arb;

    logic        clk6x = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        step;
    logic        stopped;
    logic        release_cs;
    logic        run;
    logic [3:0]  grant;
    logic        step_done;
    logic        busy;
    logic [31:0] cyc_cnt;

    logic [2:0]  ph = 3'd0;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk6x = ~clk6x;

    // Phaser model: parks at phase 0 while run is low, otherwise completes the CPU cycle.
    assign stopped    = (ph == 3'd0);
    assign release_cs = (ph == 3'd5);

    always @(posedge clk6x) begin
        if (ph != 3'd0 || run)
            ph <= (ph == 3'd5) ? 3'd0 : ph + 3'd1;
    end

    phaser_run_arb #(.NREQ(4), .CNTW(32)) dut (
        .clk6x      (clk6x),
        .reset      (reset),
        .req        (req),
        .step       (step),
        .stopped    (stopped),
        .release_cs (release_cs),
        .run        (run),
        .grant      (grant),
        .step_done  (step_done),
        .busy       (busy),
        .cyc_cnt    (cyc_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic s);
        req  = r;
        step = s;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk6x);
    endtask

    task automatic waitGrant(output int lat);
        lat = 1;
        while (grant == 4'b0000 && lat < 12) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic doStep(input string tag);
        int lat;
        int bad;
        applyStimulus(4'b0010, 1'b1);
        tick(1);
        applyStimulus(4'b0010, 1'b0);
        checkOutput({tag, "_run_hi"}, run, 1);
        tick(1);
        checkOutput({tag, "_run_lo"}, run, 0);
        lat = 1;
        bad = 0;
        while (!step_done && lat < 12) begin
            tick(1);
            lat++;
            if (run) bad++;
            if (grant != 4'b0010) bad++;
        end
        checkOutput({tag, "_lat_ok"}, (lat >= 7 && lat <= 8), 1);
        checkOutput({tag, "_held_clean"}, bad, 0);
        tick(1);
        checkOutput({tag, "_done_pulse"}, step_done, 0);
        tick(18);
    endtask

    initial begin
        int lat;
        int cnt;
        int c0;
        int bad;

        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick(3);
        checkOutput("rst_run", run, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_step_done", step_done, 0);
        checkOutput("rst_cyc", cyc_cnt, 0);

        reset = 1'b0;
        tick(1);
        checkOutput("run_after_rst", run, 1);
        checkOutput("busy_in_run", busy, 0);
        tick(6);
        checkOutput("cyc_first", cyc_cnt, 1);
        tick(6);
        checkOutput("cyc_second", cyc_cnt, 2);

        // Stop for requester 1, then release it
        applyStimulus(4'b0010, 1'b0);
        tick(1);
        checkOutput("stop_run_lo", run, 0);
        waitGrant(lat);
        checkOutput("stop_grant", grant, 4'b0010);
        checkOutput("stop_lat_ok", (lat <= 8), 1);
        checkOutput("grant_while_stopped", stopped, 1);
        checkOutput("stop_cyc", cyc_cnt, 3);
        applyStimulus(4'b0000, 1'b0);
        tick(1);
        checkOutput("release_grant", grant, 0);
        checkOutput("release_run", run, 1);

        // Three single steps by grantee 1
        applyStimulus(4'b0010, 1'b0);
        tick(1);
        waitGrant(lat);
        checkOutput("step_grant", grant, 4'b0010);
        c0 = int'(cyc_cnt);
        doStep("step1");
        doStep("step2");
        doStep("step3");
        checkOutput("step_cyc_delta", cyc_cnt - 32'(c0), 3);
        checkOutput("step_grant_kept", grant, 4'b0010);

        // Priority, handover gap and alternation
        applyStimulus(4'b0000, 1'b0);
        tick(1);
        checkOutput("back_to_run", run, 1);
        applyStimulus(4'b0011, 1'b0);
        tick(1);
        waitGrant(lat);
        checkOutput("prio_grant", grant, 4'b0001);
        bad = 0;
        applyStimulus(4'b0010, 1'b0);
        tick(1);
        checkOutput("gap_grant", grant, 0);
        if (run) bad++;
        tick(1);
        checkOutput("handover_grant", grant, 4'b0010);
        if (run) bad++;
        applyStimulus(4'b0001, 1'b0);
        tick(1);
        checkOutput("alt_gap1", grant, 0);
        if (run) bad++;
        applyStimulus(4'b0011, 1'b0);
        tick(1);
        checkOutput("alt_grant1", grant, 4'b0001);
        if (run) bad++;
        applyStimulus(4'b0010, 1'b0);
        tick(1);
        checkOutput("alt_gap2", grant, 0);
        if (run) bad++;
        applyStimulus(4'b0011, 1'b0);
        tick(1);
`ifdef PHASER_ARB_RR_EN
        checkOutput("alt_grant2", grant, 4'b0010);
`else
        checkOutput("alt_grant2", grant, 4'b0001);
`endif
        if (run) bad++;
        checkOutput("handover_run_low", bad, 0);
        applyStimulus(4'b0000, 1'b0);
        tick(1);
        checkOutput("alt_release_run", run, 1);

        // Reset in the middle of a step
        applyStimulus(4'b0010, 1'b0);
        tick(1);
        waitGrant(lat);
        checkOutput("rst_step_grant", grant, 4'b0010);
        applyStimulus(4'b0010, 1'b1);
        tick(1);
        applyStimulus(4'b0010, 1'b0);
        tick(2);
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick(1);
        checkOutput("midrst_grant", grant, 0);
        checkOutput("midrst_run", run, 0);
        checkOutput("midrst_cyc", cyc_cnt, 0);
        checkOutput("midrst_busy", busy, 1);
        reset = 1'b0;
        lat = 0;
        cnt = 0;
        while (!run && lat < 12) begin
            tick(1);
            lat++;
            if (step_done) cnt++;
        end
        checkOutput("midrst_resume_run", run, 1);
        checkOutput("midrst_resume_lat_ok", (lat <= 8), 1);
        checkOutput("midrst_no_done", cnt, 0);

        // Step while running is ignored
        applyStimulus(4'b0000, 1'b1);
        tick(1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("runstep_run", run, 1);
        checkOutput("runstep_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (step_done) cnt++;
        end
        checkOutput("runstep_no_done", cnt, 0);

        // Request withdrawn while the phaser is still finishing its cycle
        lat = 0;
        while (ph != 3'd2 && lat < 12) begin
            tick(1);
            lat++;
        end
        checkOutput("withdraw_phase_found", ph, 3'd2);
        applyStimulus(4'b0010, 1'b0);
        tick(1);
        checkOutput("withdraw_run_lo", run, 0);
        checkOutput("withdraw_busy", busy, 1);
        applyStimulus(4'b0000, 1'b0);
        lat = 0;
        cnt = 0;
        bad = 0;
        while (!run && lat < 12) begin
            tick(1);
            lat++;
            if (step_done) cnt++;
            if (grant != 4'b0000) bad++;
        end
        checkOutput("withdraw_resume_run", run, 1);
        checkOutput("withdraw_no_grant", bad, 0);
        checkOutput("withdraw_no_done", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
